// File: rtl/i2s_adc_rx.sv
// I2S capture receiver: oversamples the codec BCLK/LRCK/DAT pins, deserialises
// left/right words and queues stereo pairs in a show-ahead FIFO with valid/ready.
module i2s_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          audio_BCLK,
  input  logic                          audio_ADCLRCK,
  input  logic                          audio_ADCDAT,
  output logic [DATA_WIDTH-1:0]         sample_left,
  output logic [DATA_WIDTH-1:0]         sample_right,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  input  logic                          clear_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, HOLD} state_t;

  // Each stage carries {bclk, lrck, dat} so all three see identical delay.
  logic [2:0] sync_reg [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= '0;
          else       sync_reg[gi] <= {audio_BCLK, audio_ADCLRCK, audio_ADCDAT};
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) sync_reg[gi] <= '0;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic bclk_s, lrck_s, dat_s;
  assign {bclk_s, lrck_s, dat_s} = sync_reg[SYNC_STAGES-1];

  logic bclk_prev_reg, lrck_prev_reg;
  logic brise, boundary;
  assign brise    = bclk_s & ~bclk_prev_reg;
  assign boundary = lrck_s != lrck_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_prev_reg <= 1'b0;
      lrck_prev_reg <= 1'b0;
    end else begin
      bclk_prev_reg <= bclk_s;
      if (brise) lrck_prev_reg <= lrck_s;
    end
  end

  state_t                 state_reg;
  logic                   channel_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  left_hold_reg;
  logic                   left_valid_reg;

  logic [DATA_WIDTH-1:0]   shift_next;
  logic [CNT_W-1:0]        count_inc;
  logic                    word_done;
  logic                    push_req;
  logic [2*DATA_WIDTH-1:0] push_data;
  logic                    frame_err_set;

  always_comb begin
    shift_next    = {shift_reg[DATA_WIDTH-2:0], dat_s};
    count_inc     = count_reg + CNT_W'(1);
    word_done     = enable && brise && (state_reg == SHIFT) && !boundary && (count_inc == WORD_LAST);
    push_req      = word_done && channel_reg && left_valid_reg;
    push_data     = {left_hold_reg, shift_next};
    frame_err_set = enable && brise && (state_reg == SHIFT) && boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      channel_reg    <= 1'b0;
      count_reg      <= '0;
      shift_reg      <= '0;
      left_hold_reg  <= '0;
      left_valid_reg <= 1'b0;
    end else if (!enable) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      left_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= SYNC;
        SYNC: begin
          if (brise && boundary && !lrck_s) begin
            state_reg   <= SHIFT;
            channel_reg <= 1'b0;
            count_reg   <= '0;
          end
        end
        SHIFT: begin
          if (brise) begin
            if (boundary) begin
              // Short slot: drop the partial word and restart on the new channel.
              channel_reg <= lrck_s;
              count_reg   <= '0;
              if (lrck_s) left_valid_reg <= 1'b0;
            end else begin
              shift_reg <= shift_next;
              count_reg <= count_inc;
              if (word_done) begin
                state_reg <= HOLD;
                if (!channel_reg) begin
                  left_hold_reg  <= shift_next;
                  left_valid_reg <= 1'b1;
                end else begin
                  left_valid_reg <= 1'b0;
                end
              end
            end
          end
        end
        HOLD: begin
          if (brise && boundary) begin
            state_reg   <= SHIFT;
            channel_reg <= lrck_s;
            count_reg   <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]        level_reg, level_next;
  logic [2*DATA_WIDTH-1:0] head_reg;
  logic                    overflow_reg, frame_error_reg;
  logic                    pop, push_ok, full;

  assign sample_valid = level_reg != '0;
  assign full         = level_reg == LVL_FULL;
  assign pop          = sample_valid && sample_ready;
  assign push_ok      = push_req && (!full || pop);

  always_comb begin
    rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    level_next  = level_reg;
    if (push_ok && !pop)      level_next = level_reg + LVL_W'(1);
    else if (!push_ok && pop) level_next = level_reg - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      // Bypass the incoming pair when it lands exactly at the new head slot.
      if (level_next != '0) begin
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) head_reg <= push_data;
        else                                        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
    end else if (clear_flags) begin
      overflow_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      if (push_req && !push_ok) overflow_reg    <= 1'b1;
      if (frame_err_set)        frame_error_reg <= 1'b1;
    end
  end

  assign sample_left  = head_reg[2*DATA_WIDTH-1:DATA_WIDTH];
  assign sample_right = head_reg[DATA_WIDTH-1:0];
  assign fifo_level   = level_reg;
  assign overflow     = overflow_reg;
  assign frame_error  = frame_error_reg;

endmodule
